hw_sw_msg_tx: RTL

- Hardware-to-software message transmitter; the outbound counterpart of the software-to-hardware receive handshake.
- Game logic (slice events, score deltas, round end) pushes fixed-width message words into a small FIFO.
- The block presents each word on a PIO data port and transfers it to the NIOS software over a 2-bit four-phase handshake.
- Sits between game-state logic and the PIO bank, on the same clock as the CPU.

---
 rtl/hwsw_comm_pkg.sv | 23 ++
 rtl/msg_fifo.sv | 50 +++++
 rtl/hw_sw_msg_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/hwsw_comm_pkg.sv
// Shared hardware/software handshake codes and tx FSM types.
// Used by both the transmit and receive sides of the PIO link.
package hwsw_comm_pkg;

  localparam logic [1:0] HS_IDLE  = 2'd0;
  localparam logic [1:0] HS_DONE  = 2'd1;
  localparam logic [1:0] HS_VALID = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } tx_state_e;

  function automatic logic [1:0] hs_code(input tx_state_e s);
    case (s)
      ST_SEND:    return HS_VALID;
      ST_RELEASE: return HS_DONE;
      default:    return HS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Single-clock FIFO holding outbound message words.
// DEPTH must be a power of two so the pointers wrap naturally.
module msg_fifo #(
  parameter int MSG_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [MSG_W-1:0]       wdata,
  input  logic                   pop,
  output logic [MSG_W-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [MSG_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/hw_sw_msg_tx.sv
// Hardware-to-software message transmitter over a 2-bit four-phase PIO handshake.
// Optional macro HWSW_TX_TIMEOUT_EN adds a per-state handshake timeout.
module hw_sw_msg_tx
  import hwsw_comm_pkg::*;
#(
  parameter int MSG_W          = 16,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   msg_valid,
  input  logic [MSG_W-1:0]       msg_data,
  output logic                   msg_ready,
  output logic [MSG_W-1:0]       to_sw_data,
  output logic [1:0]             to_sw_sig,
  input  logic [1:0]             sw_ack_sig,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [7:0]             drop_count,
  output logic                   tx_error
);

  tx_state_e        state;
  tx_state_e        state_d;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             tmo_hit;
  logic             tmo_fire;
  logic [MSG_W-1:0] head;

  assign msg_ready = !full;
  assign push      = msg_valid && !full;

  msg_fifo #(
    .MSG_W (MSG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (msg_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    tmo_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && sw_ack_sig == HS_IDLE) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (sw_ack_sig == HS_VALID) begin
          state_d = ST_RELEASE;
          pop     = 1'b1;
        end else if (tmo_hit) begin
          state_d  = ST_IDLE;
          tmo_fire = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (sw_ack_sig == HS_IDLE) begin
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          state_d  = ST_IDLE;
          tmo_fire = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      to_sw_sig  <= HS_IDLE;
      to_sw_data <= '0;
    end else begin
      state     <= state_d;
      to_sw_sig <= hs_code(state_d);
      if (state == ST_IDLE && state_d == ST_SEND) to_sw_data <= head;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (msg_valid && full && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

`ifdef HWSW_TX_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt  <= '0;
      tx_error <= 1'b0;
    end else begin
      if (state_d != state)      tmo_cnt <= '0;
      else if (state != ST_IDLE) tmo_cnt <= tmo_cnt + 32'd1;
      if (tmo_fire) tx_error <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign tx_error   = 1'b0;
  assign unused_tmo = tmo_fire ^ (TIMEOUT_CYCLES > 0);
`endif

endmodule
